// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN layer pipeline: layer FSM states, the
// three-part activation index type and non-negative float helpers.
package dnn_pkg;

    localparam int INDEX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [INDEX_WIDTH-1:0] index_t;

    // [2] = channel, [1] = y, [0] = x
    typedef logic [2:0][INDEX_WIDTH-1:0] index3_t;

    // Negative doubles (sign bit set, including -0.0) become +0.0.
    function automatic logic [63:0] relu_clamp(input logic [63:0] bits);
        return bits[63] ? 64'd0 : bits;
    endfunction

    // For non-negative IEEE-754 doubles the bit patterns order like the values.
    function automatic logic [63:0] fmax_nonneg(input logic [63:0] a, input logic [63:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/act_memory.sv
// Activation memory addressed by (channel, y, x): synchronous write,
// registered read so data is valid the cycle after the index is driven.
module act_memory
    import dnn_pkg::*;
#(
    parameter int DIM       = 13,
    parameter int ENTRY_NUM = 16,
    parameter int DATA_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  index3_t              wr_index,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  index3_t              rd_index,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = ENTRY_NUM * DIM * DIM;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    function automatic logic [AW-1:0] flat_addr(input index3_t idx);
        logic [31:0] a;
        a = (32'(idx[2]) * 32'(DIM) + 32'(idx[1])) * 32'(DIM) + 32'(idx[0]);
        return a[AW-1:0];
    endfunction

    // Storage is intentionally not reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[flat_addr(wr_index)] <= wr_data;
        end
        rd_data <= mem[flat_addr(rd_index)];
    end

endmodule

// File: rtl/maxpool_layer.sv
// Max-pooling layer: streams the upstream conv output memory in window order,
// folds each POOL_DIM x POOL_DIM window into a running max of ReLU-clamped
// words and stores one pooled word per window in an internal act_memory.
module maxpool_layer
    import dnn_pkg::*;
#(
    parameter     NAME         = "MAXPOOL_LAYER_DEFAULT_NAME",
    parameter int NUM_CHANNELS = 16,
    parameter int INPUT_DIM    = 26,
    parameter int POOL_DIM     = 2,
    parameter int DATA_SIZE    = 64,
    parameter int OUTPUT_DIM   = INPUT_DIM / POOL_DIM,
    parameter int DEBUG        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output index3_t              conv_read_index,
    input  logic [DATA_SIZE-1:0] conv_read_data,
    input  index3_t              read_poolmem_index,
    output logic [DATA_SIZE-1:0] poolmem_out_data,
    output logic                 busy,
    output logic                 output_valid
);

    localparam index_t POOL_STEP = INDEX_WIDTH'(POOL_DIM);
    localparam index_t C_LAST    = INDEX_WIDTH'(NUM_CHANNELS - 1);
    localparam index_t O_LAST    = INDEX_WIDTH'(OUTPUT_DIM - 1);
    localparam index_t K_LAST    = INDEX_WIDTH'(POOL_DIM - 1);
    localparam bit     TRACE_EN  = (DEBUG != 0) && ($bits(NAME) > 0);

    state_t  state;
    index_t  c_idx, oy_idx, ox_idx, ky_idx, kx_idx;
    logic    issue;

    logic    tag_vld_p0, tag_first_p0, tag_last_p0, tag_final_p0;
    index3_t tag_addr_p0;

    logic [DATA_SIZE-1:0] run_max;
    logic [DATA_SIZE-1:0] window_max;
    logic                 first_elem, last_elem, last_window;
    logic                 pool_wr_en;

    // Address generation: upstream index follows the nested counters directly.
    always_comb begin
        first_elem      = (ky_idx == '0) && (kx_idx == '0);
        last_elem       = (ky_idx == K_LAST) && (kx_idx == K_LAST);
        last_window     = (c_idx == C_LAST) && (oy_idx == O_LAST) && (ox_idx == O_LAST);
        conv_read_index = {c_idx, oy_idx * POOL_STEP + ky_idx, ox_idx * POOL_STEP + kx_idx};
    end

    // Control FSM, read counters and the tag stage that tracks the outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            output_valid <= 1'b0;
            issue        <= 1'b0;
            c_idx        <= '0;
            oy_idx       <= '0;
            ox_idx       <= '0;
            ky_idx       <= '0;
            kx_idx       <= '0;
            tag_vld_p0   <= 1'b0;
            tag_first_p0 <= 1'b0;
            tag_last_p0  <= 1'b0;
            tag_final_p0 <= 1'b0;
            tag_addr_p0  <= '0;
        end else begin
            // ---- stage p0: tag travels one cycle behind the driven address ----
            tag_vld_p0   <= issue;
            tag_first_p0 <= first_elem;
            tag_last_p0  <= last_elem;
            tag_final_p0 <= last_window;
            tag_addr_p0  <= {c_idx, oy_idx, ox_idx};

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        output_valid <= 1'b0;
                        issue        <= 1'b1;
                        c_idx        <= '0;
                        oy_idx       <= '0;
                        ox_idx       <= '0;
                        ky_idx       <= '0;
                        kx_idx       <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_elem && last_window) begin
                            issue <= 1'b0;
                        end
                        if (kx_idx != K_LAST) begin
                            kx_idx <= kx_idx + 1'b1;
                        end else begin
                            kx_idx <= '0;
                            if (ky_idx != K_LAST) begin
                                ky_idx <= ky_idx + 1'b1;
                            end else begin
                                ky_idx <= '0;
                                if (ox_idx != O_LAST) begin
                                    ox_idx <= ox_idx + 1'b1;
                                end else begin
                                    ox_idx <= '0;
                                    if (oy_idx != O_LAST) begin
                                        oy_idx <= oy_idx + 1'b1;
                                    end else begin
                                        oy_idx <= '0;
                                        c_idx  <= (c_idx == C_LAST) ? '0 : c_idx + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    if (tag_vld_p0 && tag_last_p0 && tag_final_p0) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        output_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fold: the first element of a window replaces the running max outright.
    always_comb begin
        window_max = fmax_nonneg(tag_first_p0 ? '0 : run_max, relu_clamp(conv_read_data));
        pool_wr_en = tag_vld_p0 && tag_last_p0;
    end

    // Running max register, updated once per returning upstream word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max <= '0;
        end else if (tag_vld_p0) begin
            run_max <= window_max;
        end
    end

    // Hook for per-window tracing; left empty so only synthesizable logic remains.
    if (TRACE_EN) begin : g_trace
    end

    act_memory #(
        .DIM       (OUTPUT_DIM),
        .ENTRY_NUM (NUM_CHANNELS),
        .DATA_SIZE (DATA_SIZE)
    ) u_poolmem (
        .clk      (clk),
        .wr_en    (pool_wr_en),
        .wr_index (tag_addr_p0),
        .wr_data  (window_max),
        .rd_index (read_poolmem_index),
        .rd_data  (poolmem_out_data)
    );

endmodule

// File: tb/tb_maxpool_layer.sv
// Bench for maxpool_layer: upstream conv memory model, reference pooling model
// feeding an expected-value queue, readback of the pooled memory after each run.
module tb_maxpool_layer;
    import dnn_pkg::*;

    localparam int NC = 2;
    localparam int ID = 5;
    localparam int PD = 2;
    localparam int OD = ID / PD;
    localparam int K  = NC * OD * OD * PD * PD;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    index3_t     conv_read_index;
    index3_t     read_poolmem_index;
    logic [63:0] conv_read_data;
    logic [63:0] poolmem_out_data;
    logic        busy;
    logic        output_valid;

    logic [63:0] conv_mem [NC][ID][ID];
    logic [63:0] exp_q [$];
    index3_t     addr_q [$];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    maxpool_layer #(
        .NAME         ("TB_POOL"),
        .NUM_CHANNELS (NC),
        .INPUT_DIM    (ID),
        .POOL_DIM     (PD),
        .DATA_SIZE    (64),
        .OUTPUT_DIM   (OD),
        .DEBUG        (0)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .conv_read_index    (conv_read_index),
        .conv_read_data     (conv_read_data),
        .read_poolmem_index (read_poolmem_index),
        .poolmem_out_data   (poolmem_out_data),
        .busy               (busy),
        .output_valid       (output_valid)
    );

    // Upstream conv output memory: data valid the cycle after the index.
    always @(posedge clk) begin
        if (int'(conv_read_index[2]) < NC && int'(conv_read_index[1]) < ID && int'(conv_read_index[0]) < ID)
            conv_read_data <= conv_mem[int'(conv_read_index[2])][int'(conv_read_index[1])][int'(conv_read_index[0])];
        else
            conv_read_data <= 64'd0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference pooling in the real domain: max(0, window max).
    task automatic push_expected();
        for (int c = 0; c < NC; c++)
            for (int oy = 0; oy < OD; oy++)
                for (int ox = 0; ox < OD; ox++) begin
                    real mx;
                    mx = 0.0;
                    for (int ky = 0; ky < PD; ky++)
                        for (int kx = 0; kx < PD; kx++)
                            if ($bitstoreal(conv_mem[c][oy*PD+ky][ox*PD+kx]) > mx)
                                mx = $bitstoreal(conv_mem[c][oy*PD+ky][ox*PD+kx]);
                    exp_q.push_back($realtobits(mx));
                end
    endtask

    function automatic int seq_errors();
        int e;
        int i;
        e = (addr_q.size() != K) ? 1 : 0;
        i = 0;
        for (int c = 0; c < NC; c++)
            for (int oy = 0; oy < OD; oy++)
                for (int ox = 0; ox < OD; ox++)
                    for (int ky = 0; ky < PD; ky++)
                        for (int kx = 0; kx < PD; kx++) begin
                            index3_t a;
                            a[2] = 16'(c);
                            a[1] = 16'(oy * PD + ky);
                            a[0] = 16'(ox * PD + kx);
                            if (i < addr_q.size() && addr_q[i] !== a) e++;
                            i++;
                        end
        return e;
    endfunction

    task automatic load_basic();
        for (int c = 0; c < NC; c++)
            for (int y = 0; y < ID; y++)
                for (int x = 0; x < ID; x++)
                    if (y == 4 || x == 4) conv_mem[c][y][x] = $realtobits(99.0);
                    else if (c == 0)      conv_mem[c][y][x] = $realtobits(real'(y * 4 + x + 1));
                    else                  conv_mem[c][y][x] = $realtobits(real'(50 - y * 7 + x * 3));
    endtask

    task automatic load_random();
        for (int c = 0; c < NC; c++)
            for (int y = 0; y < ID; y++)
                for (int x = 0; x < ID; x++)
                    conv_mem[c][y][x] = $realtobits(real'($urandom_range(0, 2000)) / 8.0 - 125.0);
    endtask

    task automatic read_pool(input int c, input int y, input int x, output logic [63:0] data);
        read_poolmem_index[2] = 16'(c);
        read_poolmem_index[1] = 16'(y);
        read_poolmem_index[0] = 16'(x);
        @(posedge clk);
        #1;
        data = poolmem_out_data;
    endtask

    // Starts a run from #1 after an edge; n counts edges after E0.
    task automatic do_run(input int pulse_at, input int rst_at, output int done_edge,
                          output int busy_low, output int bad_reads);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        addr_q.delete();
        done_edge = -1;
        busy_low  = 0;
        bad_reads = 0;
        for (int n = 0; n <= K + 10; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (output_valid) begin
                done_edge = n;
                break;
            end
            if (n < K) begin
                addr_q.push_back(conv_read_index);
                if (int'(conv_read_index[1]) >= OD * PD || int'(conv_read_index[0]) >= OD * PD)
                    bad_reads++;
            end
            if (!busy) busy_low++;
            start = (n == pulse_at);
            if (n == rst_at) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        read_poolmem_index = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b expected 0", busy);
        end
        n_cmp++;
        if (output_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b expected 0", output_valid);
        end
        n_cmp++;
        if (conv_read_index !== index3_t'(0)) begin
            n_fail++; $display("FAIL reset_index got %h expected 0", conv_read_index);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int done_edge, busy_low, bad_reads, hits99;
        logic [63:0] got, exp;
        load_basic();
        push_expected();
        do_run(-1, -1, done_edge, busy_low, bad_reads);
        n_cmp++;
        if (done_edge !== K + 1) begin
            n_fail++; $display("FAIL basic_latency got %0d expected %0d", done_edge, K + 1);
        end
        n_cmp++;
        if (busy_low !== 0) begin
            n_fail++; $display("FAIL basic_busy low_cycles %0d expected 0", busy_low);
        end
        n_cmp++;
        if (bad_reads !== 0) begin
            n_fail++; $display("FAIL basic_edge_reads got %0d expected 0", bad_reads);
        end
        n_cmp++;
        if (seq_errors() !== 0) begin
            n_fail++; $display("FAIL basic_addr_seq errors %0d expected 0", seq_errors());
        end
        hits99 = 0;
        for (int c = 0; c < NC; c++)
            for (int oy = 0; oy < OD; oy++)
                for (int ox = 0; ox < OD; ox++) begin
                    read_pool(c, oy, ox, got);
                    exp = exp_q.pop_front();
                    if (got === $realtobits(99.0)) hits99++;
                    n_cmp++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL basic_pool[%0d][%0d][%0d] got %h expected %h", c, oy, ox, got, exp);
                    end
                end
        n_cmp++;
        if (hits99 !== 0) begin
            n_fail++; $display("FAIL basic_no_99 got %0d expected 0", hits99);
        end
        n_cmp++;
        if (output_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_hold valid %b busy %b expected 1 0", output_valid, busy);
        end
    endtask

    task automatic test_negative();
        int done_edge, busy_low, bad_reads, negz;
        logic [63:0] got, exp;
        for (int y = 0; y < ID; y++)
            for (int x = 0; x < ID; x++) begin
                conv_mem[0][y][x] = ((y + x) % 3 == 0) ? $realtobits(-real'(y + x + 1)) : $realtobits(real'(x) * 0.5);
                conv_mem[1][y][x] = $realtobits(-1.0 - real'(y + x));
            end
        conv_mem[0][0][0] = 64'h8000_0000_0000_0000;
        conv_mem[0][0][1] = 64'h8000_0000_0000_0000;
        conv_mem[0][1][0] = 64'h8000_0000_0000_0000;
        conv_mem[1][2][3] = $realtobits(2.5);
        push_expected();
        do_run(-1, -1, done_edge, busy_low, bad_reads);
        n_cmp++;
        if (done_edge !== K + 1) begin
            n_fail++; $display("FAIL neg_latency got %0d expected %0d", done_edge, K + 1);
        end
        negz = 0;
        for (int c = 0; c < NC; c++)
            for (int oy = 0; oy < OD; oy++)
                for (int ox = 0; ox < OD; ox++) begin
                    read_pool(c, oy, ox, got);
                    exp = exp_q.pop_front();
                    if (got[63] !== 1'b0) negz++;
                    n_cmp++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL neg_pool[%0d][%0d][%0d] got %h expected %h", c, oy, ox, got, exp);
                    end
                end
        n_cmp++;
        if (negz !== 0) begin
            n_fail++; $display("FAIL neg_sign_bits got %0d expected 0", negz);
        end
    endtask

    task automatic test_start_ignored();
        int done_edge, busy_low, bad_reads;
        logic [63:0] got, exp;
        load_random();
        push_expected();
        do_run(5, -1, done_edge, busy_low, bad_reads);
        n_cmp++;
        if (done_edge !== K + 1) begin
            n_fail++; $display("FAIL ignore_latency got %0d expected %0d", done_edge, K + 1);
        end
        n_cmp++;
        if (seq_errors() !== 0) begin
            n_fail++; $display("FAIL ignore_addr_seq errors %0d expected 0", seq_errors());
        end
        for (int c = 0; c < NC; c++)
            for (int oy = 0; oy < OD; oy++)
                for (int ox = 0; ox < OD; ox++) begin
                    read_pool(c, oy, ox, got);
                    exp = exp_q.pop_front();
                    n_cmp++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL ignore_pool[%0d][%0d][%0d] got %h expected %h", c, oy, ox, got, exp);
                    end
                end
    endtask

    task automatic test_reset_mid_run();
        int done_edge, busy_low, bad_reads;
        logic [63:0] got, exp;
        load_random();
        do_run(-1, 7, done_edge, busy_low, bad_reads);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || output_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async busy %b valid %b expected 0 0", busy, output_valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || output_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_held busy %b valid %b expected 0 0", busy, output_valid);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle busy %b expected 0", busy);
        end
        push_expected();
        do_run(-1, -1, done_edge, busy_low, bad_reads);
        n_cmp++;
        if (done_edge !== K + 1) begin
            n_fail++; $display("FAIL midrst_latency got %0d expected %0d", done_edge, K + 1);
        end
        for (int c = 0; c < NC; c++)
            for (int oy = 0; oy < OD; oy++)
                for (int ox = 0; ox < OD; ox++) begin
                    read_pool(c, oy, ox, got);
                    exp = exp_q.pop_front();
                    n_cmp++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL midrst_pool[%0d][%0d][%0d] got %h expected %h", c, oy, ox, got, exp);
                    end
                end
    endtask

    task automatic test_back_to_back();
        int t1, t2, high_cycles;
        logic [63:0] got, exp;
        load_random();
        push_expected();
        t1 = -1;
        t2 = -1;
        high_cycles = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n <= 3 * K; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (output_valid) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0 && high_cycles > 0 && n > t1 + 1) t2 = n;
                if (t2 < 0) high_cycles++;
            end
            if (t2 >= 0) break;
        end
        start = 1'b0;
        n_cmp++;
        if (t1 !== K + 1) begin
            n_fail++; $display("FAIL b2b_first_done got %0d expected %0d", t1, K + 1);
        end
        n_cmp++;
        if (t2 !== 2 * K + 3) begin
            n_fail++; $display("FAIL b2b_second_done got %0d expected %0d", t2, 2 * K + 3);
        end
        n_cmp++;
        if (high_cycles !== 1) begin
            n_fail++; $display("FAIL b2b_valid_width got %0d expected 1", high_cycles);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (output_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done_hold got %b expected 1", output_valid);
        end
        for (int c = 0; c < NC; c++)
            for (int oy = 0; oy < OD; oy++)
                for (int ox = 0; ox < OD; ox++) begin
                    read_pool(c, oy, ox, got);
                    exp = exp_q.pop_front();
                    n_cmp++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_pool[%0d][%0d][%0d] got %h expected %h", c, oy, ox, got, exp);
                    end
                end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        read_poolmem_index = '0;
        test_reset();
        test_basic();
        test_negative();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool_layer.md
# maxpool_layer

Max-pooling stage that sits directly downstream of the convolution layer. After the conv layer raises `output_valid`, this block walks the conv output memory through its read-index port. It reduces each non-overlapping POOL_DIM×POOL_DIM window per channel to its maximum and writes the result into an internal pooled-activation memory. The next layer reads that memory through the same index-triple style of port.

## Interface
Parameters:
- NAME, "MAXPOOL_LAYER_DEFAULT_NAME": prefix for debug `$display` output.
- NUM_CHANNELS, 16: feature maps; equals the upstream conv NUM_OUTPUTS.
- INPUT_DIM, 26: upstream conv OUTPUT_DIM.
- POOL_DIM, 2: window edge and stride.
- DATA_SIZE, 64: word width, IEEE-754 double bit pattern.
- OUTPUT_DIM, INPUT_DIM/POOL_DIM: pooled edge, floor division.
- DEBUG, 0: enables per-window `$display`.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level; sampled in IDLE or DONE; typically tied to the upstream `output_valid`.
- conv_read_index  out  16×[2:0]  [2]=channel, [1]=y, [0]=x into the upstream `read_outmem_index`.
- conv_read_data  in  DATA_SIZE  upstream `outmem_out_data`; valid the cycle after the index is driven.
- read_poolmem_index  in  16×[2:0]  downstream read index, same layout.
- poolmem_out_data  out  DATA_SIZE  pooled word; valid the cycle after the index is driven.
- busy  out  1  high in RUN.
- output_valid  out  1  pooled memory complete.

## Operation
- States:
  - IDLE: reset state.
  - RUN: issue one upstream read per cycle.
  - DONE: holds `output_valid`.
- Transitions:
  - IDLE→RUN when `start`=1.
  - RUN→DONE when the final window write occurs.
  - DONE→RUN when `start`=1. This clears `output_valid` and restarts from index 0.
  - `start` in RUN is ignored.
- Read order, outermost to innermost: channel c, pooled row oy, pooled col ox, ky, kx.
  - Driven address: channel=c, y=oy·POOL_DIM+ky, x=ox·POOL_DIM+kx.
- Window reduction:
  - Running max register; the first element of each window loads it unconditionally.
  - Operand clamp: any word with bit 63 set (negative) is replaced by +0.0 before use.
  - Comparison: clamped operands are non-negative, so max is an unsigned compare of the 64-bit patterns. No real arithmetic is used.
  - NaN inputs are undefined.
- Pooled write: on the cycle the last element (ky=kx=POOL_DIM-1) returns, write max(running, clamped data) to pool memory at [c][oy][ox].
- Odd INPUT_DIM: trailing row and column beyond OUTPUT_DIM·POOL_DIM are never read.
- Pool memory is not cleared by `rst`. Contents are defined only for indices written since the last `start`.

## Timing
- Let K = NUM_CHANNELS·OUTPUT_DIM²·POOL_DIM², and let the edge sampling `start` be E0.
  - Address n is driven during cycle n, for n = 0..K-1.
  - Its data is folded at edge E(n+2).
  - The final pool write and the rise of `output_valid` both occur at E(K+1).
  - `busy` is high from E0 to E(K+1).
- Pipeline: one tag stage (window-first, window-last, pooled address) accompanies each outstanding read. Addresses advance every cycle with no stalls.
- Reset values: `conv_read_index` all 0, `busy`=0, `output_valid`=0, state IDLE, running max 0, tag-valid 0.
- `rst` mid-RUN: immediate abort to IDLE. Partially written pool memory is retained but invalid. The next `start` recomputes everything.
- `start` held high through DONE: a new run begins on the edge after DONE is entered. `output_valid` is high for exactly one cycle.

## Structure
- Shared package `dnn_pkg`:
  - state enum (IDLE/RUN/DONE)
  - INDEX_WIDTH=16
  - function `relu_clamp(bits)` and function `fmax_nonneg(a,b)`, reusable by later layers.
- Pool storage: instantiate the existing `act_memory` with DIM=OUTPUT_DIM, ENTRY_NUM=NUM_CHANNELS, DATA_SIZE=DATA_SIZE. The write is a one-cycle pulse; the read port is tied to `read_poolmem_index`.
- No other sub-module. The index counters and compare stay in this module.

## Test plan
- Run config: NUM_CHANNELS=1, INPUT_DIM=4, POOL_DIM=2; upstream rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}.
  - Expect pooled {6,8},{14,16}.
  - Expect `output_valid` rising exactly 17 edges after E0.
- Run 2 channels, INPUT_DIM=4: channel 1 all negative except one value of 2.5.
  - Expect channel 1 windows 0.0 everywhere except 2.5 in that window.
  - Expect no −0.0 bit pattern.
- Run INPUT_DIM=5, POOL_DIM=2 with row 4 and column 4 set to 99.0.
  - Expect OUTPUT_DIM=2, no output equal to 99.0, and no read of y=4 or x=4.
- Pulse `start` again at cycle 5 of a run.
  - Expect it ignored: address sequence and completion time unchanged.
- Assert `rst` at cycle 7, release, then `start` again.
  - Expect `busy`=0 and `output_valid`=0 during reset.
  - Expect the full correct result after the second run.
- Hold `start` high continuously.
  - Expect back-to-back runs, with `output_valid` one cycle high per run and identical results.
